// File: rtl/ifu_inst_queue.sv
// Instruction fetch queue: small circular FIFO of {pc, inst} pairs between
// fetch and decode, with valid/ready on both sides and a flush for redirects.
// Outputs are driven from registered state only, so no input reaches an
// output through combinational logic.
module ifu_inst_queue #(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 64,
    parameter  int IW    = 32,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [IW-1:0]   in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [IW-1:0]   out_inst,
    output logic [CW-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [IW-1:0]   inst;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            full, empty, push, pop;
    entry_t          head;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

    // Handshake outputs depend only on occupancy, never on this cycle's inputs.
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Flush wins over both handshakes.
    assign push = in_valid  & in_ready  & !flush;
    assign pop  = out_valid & out_ready & !flush;

    assign head     = mem[rd_ptr];
    assign out_pc   = head.pc;
    assign out_inst = head.inst;
    assign count    = cnt;

    // Entry storage; not reset, contents are only observed while out_valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Bench for ifu_inst_queue: hand-derived occupancy table, a queue scoreboard
// for data ordering, plus reset, streaming and pointer-wrap sequences.
module tb_ifu_inst_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int IW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] in_pc = '0;
    logic [IW-1:0]   in_inst = '0;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [IW-1:0]   out_inst;
    logic [CW-1:0]   count;

    ifu_inst_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [IW-1:0]   inst;
    } ent_t;

    typedef struct {
        bit              f;
        bit              iv;
        bit              ordy;
        logic [XLEN-1:0] pc;
        int              exp_cnt;
    } vec_t;

    ent_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [IW-1:0] inst_of(input logic [XLEN-1:0] pc);
        return pc[IW-1:0] ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. Outputs are checked against the scoreboard at
    // the falling edge; exp_cnt (if >= 0) is a hand-derived occupancy after the edge.
    task automatic step(input bit f, input bit iv, input bit ordy,
                        input logic [XLEN-1:0] pc, input logic [IW-1:0] inst,
                        input int exp_cnt);
        bit full;
        flush = f; in_valid = iv; out_ready = ordy; in_pc = pc; in_inst = inst;
        @(negedge clk);
        full = (sb.size() == DEPTH);
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(!full));
        chk("count", 64'(count), 64'(sb.size()));
        if (sb.size() != 0) begin
            chk("out_pc", out_pc, sb[0].pc);
            chk("out_inst", 64'(out_inst), 64'(sb[0].inst));
        end
        if (f) begin
            sb.delete();
        end else begin
            if (ordy && sb.size() != 0)
                void'(sb.pop_front());
            if (iv && !full)
                sb.push_back('{pc: pc, inst: inst});
        end
        @(posedge clk); #1;
        if (exp_cnt >= 0)
            chk("count_table", 64'(count), 64'(exp_cnt));
    endtask

    vec_t vecs [15];

    initial begin
        int pushed;
        int budget;

        // Reset held from time 0.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Fill, full refusal, full+pop, drain, empty pop, flush priority.
        vecs[0]  = '{0, 1, 0, 64'h8000_0000, 1};
        vecs[1]  = '{0, 1, 0, 64'h8000_0004, 2};
        vecs[2]  = '{0, 1, 0, 64'h8000_0008, 3};
        vecs[3]  = '{0, 1, 0, 64'h8000_000C, 4};
        vecs[4]  = '{0, 1, 0, 64'h8000_0010, 4};
        vecs[5]  = '{0, 1, 1, 64'h8000_0010, 3};
        vecs[6]  = '{0, 0, 1, 64'h0,         2};
        vecs[7]  = '{0, 0, 1, 64'h0,         1};
        vecs[8]  = '{0, 0, 1, 64'h0,         0};
        vecs[9]  = '{0, 0, 1, 64'h0,         0};
        vecs[10] = '{0, 1, 0, 64'h8000_0020, 1};
        vecs[11] = '{0, 1, 0, 64'h8000_0024, 2};
        vecs[12] = '{1, 1, 1, 64'h8000_0028, 0};
        vecs[13] = '{0, 1, 1, 64'h8000_1000, 1};
        vecs[14] = '{0, 0, 1, 64'h0,         0};
        for (int i = 0; i < 15; i++)
            step(vecs[i].f, vecs[i].iv, vecs[i].ordy, vecs[i].pc,
                 inst_of(vecs[i].pc), vecs[i].exp_cnt);

        // Asynchronous reset mid-traffic with three entries queued.
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 64'h8000_0100 + 64'(4 * i), inst_of(64'h8000_0100 + 64'(4 * i)), i + 1);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        chk("async_rst_count", 64'(count), 64'd0);
        sb.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        step(0, 1, 0, 64'h8000_0000, 32'h0000_0013, 1);
        step(0, 0, 1, 64'h0, 32'h0, 0);

        // Streaming: one entry per cycle, occupancy steady at 1.
        for (int i = 0; i < 20; i++)
            step(0, 1, 1, 64'h8000_0000 + 64'(4 * i), inst_of(64'h8000_0000 + 64'(4 * i)), 1);
        step(0, 0, 1, 64'h0, 32'h0, 0);

        // Pointer wrap: 3*DEPTH+1 accepted pushes with random decode stalls.
        pushed = 0;
        budget = 0;
        while (pushed < 3 * DEPTH + 1 && budget < 500) begin
            logic [XLEN-1:0] pc;
            pc = 64'h8000_2000 + 64'(4 * pushed);
            if (sb.size() < DEPTH)
                pushed++;
            step(0, 1, bit'($urandom_range(0, 2) == 0), pc, inst_of(pc), -1);
            budget++;
        end
        chk("wrap_push_budget", 64'(pushed), 64'(3 * DEPTH + 1));
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            step(0, 0, bit'($urandom_range(0, 1)), 64'h0, 32'h0, -1);
            budget++;
        end
        chk("wrap_drain_empty", 64'(sb.size()), 64'd0);
        chk("wrap_final_count", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_inst_queue.md
Name: ifu_inst_queue

Overview:
Instruction fetch queue sitting directly downstream of the fetch unit (PC register + fetch) and upstream of decode. It buffers fetched {pc, inst} pairs in a small circular FIFO and decouples fetch from decode stalls using valid/ready handshakes on both sides. A flush input discards all buffered entries on redirect (branch or exception).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 64, PC width
IW, 32, instruction width
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset; asserting (0) clears state immediately, deassertion is synchronous to clk
flush  input  1  discard all entries this cycle
in_valid  input  1  fetch presents an entry
in_ready  output  1  queue can accept an entry
in_pc  input  XLEN  PC of fetched instruction
in_inst  input  IW  fetched instruction word
out_valid  output  1  head entry valid to decode
out_ready  input  1  decode accepts head entry
out_pc  output  XLEN  PC of head entry
out_inst  output  IW  instruction of head entry
count  output  CW  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x (XLEN+IW) entry array; wr_ptr and rd_ptr of log2(DEPTH) bits, wrapping DEPTH-1 -> 0; occupancy counter cnt (CW bits).
- full = (cnt == DEPTH); empty = (cnt == 0).
- in_ready = !full; combinational from state only, never from in_valid or out_ready.
- out_valid = !empty; out_pc/out_inst = entry[rd_ptr]; combinational from state only. No comb path from inputs to outputs.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- On push: entry[wr_ptr] <= {in_pc, in_inst}; wr_ptr++.
- On pop: rd_ptr++.
- cnt update: push & !pop -> +1; pop & !push -> -1; both or neither -> unchanged.
- Latency: entry pushed in cycle N is visible on out_* in cycle N+1 (no same-cycle bypass when empty).
- Full: in_ready=0 even if out_ready=1 the same cycle; no push-through while full. A pop while full raises in_ready in the next cycle.
- Empty: out_valid=0; out_ready ignored; out_pc/out_inst hold stale array contents (don't-care, not checked).
- Simultaneous push+pop with 0<cnt<DEPTH: both pointers advance, cnt unchanged, FIFO order preserved.
- Flush: highest priority. On a flush cycle, wr_ptr, rd_ptr and cnt go to 0 at the next edge; push and pop in that cycle are suppressed (in_valid/out_ready ignored). The cycle after flush, out_valid=0 and in_ready=1. Array contents need not be cleared.
- Reset (rst=0, asynchronous, including mid-operation): wr_ptr=0, rd_ptr=0, cnt=0, so out_valid=0, in_ready=1, count=0. The array is not reset; out_pc/out_inst are don't-care while out_valid=0.
- count = cnt, registered.
- Ordering invariant: entries leave in exactly the order they were accepted; no entry is duplicated or dropped except by flush/reset.

Test Plan:
- Reset/idle: rst=0 mid-traffic with cnt=3 -> immediately out_valid=0, in_ready=1, count=0; after release, first push pc=0x80000000 inst=0x00000013 appears on out_* one cycle later.
- Fill to full: out_ready=0, push pc 0x80000000,04,08,0C -> count=4, in_ready=0; a fifth in_valid (pc 0x80000010) is not accepted; then drain with out_ready=1 -> pcs emerge 0x...00,04,08,0C in order, count reaches 0.
- Streaming: in_valid=1, out_ready=1 continuously over 20 sequential PCs starting 0x80000000 -> after 1-cycle fill latency, one entry per cycle, count steady at 1, all 20 PCs in order with no gaps.
- Full + simultaneous pop: cnt=4, in_valid=1, out_ready=1 -> the pop occurs and the push is refused (in_ready=0); next cycle count=3, in_ready=1.
- Flush priority: cnt=2, flush=1 with in_valid=1 and out_ready=1 in the same cycle -> no entry is consumed or written; next cycle count=0, out_valid=0; a following push of pc=0x80001000 emerges first.
- Pointer wrap: 3*DEPTH+1 push/pop mix with random out_ready stalls -> scoreboard confirms FIFO order, count always matches the model, never exceeds 4, never underflows.
